// File: rtl/keyscan_pkg.sv
// Shared constants, key-code type and slot priority helper for the keyboard scan decoder.
package keyscan_pkg;

    localparam int unsigned NUM_SLOTS       = 13;
    localparam int unsigned SLOT_PITCH      = 10;
    localparam int unsigned SLOT_CENTRE_OFS = 10;
    localparam int unsigned COUNT_W         = 10;

    typedef enum logic [3:0] {
        KEY_0     = 4'd0,
        KEY_1     = 4'd1,
        KEY_2     = 4'd2,
        KEY_3     = 4'd3,
        KEY_4     = 4'd4,
        KEY_5     = 4'd5,
        KEY_6     = 4'd6,
        KEY_7     = 4'd7,
        KEY_8     = 4'd8,
        KEY_9     = 4'd9,
        KEY_ENTER = 4'd10,
        KEY_CLOCK = 4'd11,
        KEY_ALARM = 4'd12
    } key_code_t;

    // Lowest set index wins; an all-zero frame maps to KEY_0.
    function automatic key_code_t lowest_set(input logic [12:0] bits);
        key_code_t code;
        code = KEY_0;
        for (int i = 12; i >= 0; i--) begin
            if (bits[i]) begin
                code = key_code_t'(4'(i));
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keyscan_debounce.sv
// Frame debouncer: match counter, stable frame, new-press strobe and optional hold repeat.
// Hold auto-repeat is built only when KEYSCAN_HOLD_REPEAT_EN is defined.
module keyscan_debounce
    import keyscan_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned REPEAT_FRAMES   = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 commit,
    input  logic [NUM_SLOTS-1:0] raw,
    output logic [3:0]           key_code,
    output logic                 key_valid,
    output logic                 key_down,
    output logic                 frame_done
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

    logic [NUM_SLOTS-1:0] prev_q, stable_q, stable_d, rise;
    logic [3:0]           match_q, match_d;
    key_code_t            code_q, code_d;
    logic                 valid_q, valid_d, done_q;

`ifdef KEYSCAN_HOLD_REPEAT_EN
    localparam logic [15:0] REP = 16'(REPEAT_FRAMES);
    logic [15:0] rep_q, rep_d;
`else
    localparam bit unused_repeat = (REPEAT_FRAMES != 0);
`endif

    always_comb begin
        match_d  = match_q;
        stable_d = stable_q;
        if (commit) begin
            if (raw == prev_q) begin
                match_d = (match_q >= DEB) ? DEB : match_q + 4'd1;
            end else begin
                match_d = 4'd1;
            end
            if (match_d == DEB && raw != stable_q) begin
                stable_d = raw;
            end
        end
        // rise can only be non-zero on a commit cycle
        rise    = stable_d & ~stable_q;
        valid_d = |rise;
        code_d  = code_q;
        if (valid_d) begin
            code_d = lowest_set(rise);
        end
`ifdef KEYSCAN_HOLD_REPEAT_EN
        rep_d = rep_q;
        if (commit) begin
            if (stable_d != stable_q) begin
                rep_d = '0;
            end else if (|stable_q) begin
                if (rep_q + 16'd1 == REP) begin
                    rep_d   = '0;
                    valid_d = 1'b1;
                    code_d  = lowest_set(stable_q);
                end else begin
                    rep_d = rep_q + 16'd1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= '0;
            stable_q <= '0;
            match_q  <= '0;
            code_q   <= KEY_0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef KEYSCAN_HOLD_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            match_q  <= match_d;
            stable_q <= stable_d;
            if (commit) begin
                prev_q <= raw;
            end
            code_q  <= code_d;
            valid_q <= valid_d;
            done_q  <= commit;
`ifdef KEYSCAN_HOLD_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign key_code   = code_q;
    assign key_valid  = valid_q;
    assign key_down   = |stable_q;
    assign frame_done = done_q;

endmodule

// File: rtl/keyscan_decoder.sv
// Scan-count driver and slot sampler for the keyboard multiplexer; feeds keyscan_debounce.
// Optional hold auto-repeat is enabled by defining KEYSCAN_HOLD_REPEAT_EN.
module keyscan_decoder
    import keyscan_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 1,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned REPEAT_FRAMES   = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               signal,
    input  logic               scan_rst,
    output logic [COUNT_W-1:0] count,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_down,
    output logic               frame_done
);

    logic [15:0]          presc_q;
    logic                 step_en, commit;
    logic [COUNT_W-1:0]   count_q;
    logic [NUM_SLOTS-1:0] raw_q, raw_d, slot_hit;

    // TICK_DIV = 1 keeps presc_q at zero, so step_en is constantly high
    assign step_en = (presc_q == 16'(TICK_DIV - 1));
    assign commit  = step_en & scan_rst;

    always_comb begin
        slot_hit = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            slot_hit[k] = (count_q == COUNT_W'(SLOT_CENTRE_OFS + SLOT_PITCH * k));
        end
        raw_d = raw_q;
        if (step_en) begin
            if (scan_rst) begin
                raw_d = '0;
            end else begin
                for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                    if (slot_hit[k]) begin
                        raw_d[k] = signal;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            raw_q   <= '0;
        end else begin
            presc_q <= step_en ? 16'd0 : presc_q + 16'd1;
            if (step_en) begin
                count_q <= scan_rst ? '0 : count_q + 1'b1;
            end
            raw_q <= raw_d;
        end
    end

    assign count = count_q;

    keyscan_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .commit     (commit),
        .raw        (raw_q),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_down   (key_down),
        .frame_done (frame_done)
    );

endmodule
